// File: rtl/dctq_block_sched_if.sv
// Bundle of the host row stream, the DCTQ input-RAM write port and the
// DCTQ controller handshake for dctq_block_sched.
//
// Handshakes: a host row moves on a rising edge where host_valid and
// host_ready are both 1; host_data must be stable while host_valid waits.
// start is a single-cycle pulse, only ever raised while ready is 1.
// A block completes on any cycle with dctq_valid = 1 and addr = 63.
interface dctq_block_sched_if #(
    parameter int FB_W = 16
);
    logic            frame_go;
    logic [FB_W-1:0] frame_blocks;
    logic            host_valid;
    logic [63:0]     host_data;
    logic            host_ready;
    logic [63:0]     di;
    logic            din_valid;
    logic [2:0]      wa;
    logic [7:0]      be;
    logic            start;
    logic            ready;
    logic            dctq_valid;
    logic [5:0]      addr;
    logic            busy;
    logic            frame_done;
    logic [1:0]      state_dbg;

    modport slave (
        input  frame_go, frame_blocks, host_valid, host_data,
               ready, dctq_valid, addr,
        output host_ready, di, din_valid, wa, be, start, busy,
               frame_done, state_dbg
    );

    modport master (
        output frame_go, frame_blocks, host_valid, host_data,
               ready, dctq_valid, addr,
        input  host_ready, di, din_valid, wa, be, start, busy,
               frame_done, state_dbg
    );
endinterface

// File: rtl/dctq_block_sched.sv
// Frame scheduler in front of a DCTQ core: loads eight host rows per 8x8
// block into the DCTQ input RAM, fires start once a block is complete, and
// keeps at most two blocks in flight inside the DCTQ until the frame ends.
// The interface instance must use the same FB_W as this module.
module dctq_block_sched #(
    parameter int FB_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dctq_block_sched_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_PEND  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [FB_W-1:0] fb_q;
    logic [FB_W-1:0] blk_in_q;
    logic [FB_W-1:0] blk_out_q;
    logic [FB_W-1:0] in_flight;
    logic [FB_W:0]   blk_in_next;
    logic [2:0]      row_q;
    logic [63:0]     di_q;
    logic [2:0]      wa_q;
    logic [7:0]      be_q;
    logic            din_valid_q;
    logic            go_ok;
    logic            row_acc;
    logic            blk_done;
    logic            start_c;
    logic            frame_done_c;

    // A zero-block frame_go is treated as if it never happened.
    assign go_ok       = bus.frame_go && (bus.frame_blocks != '0);
    assign row_acc     = bus.host_valid && (state_q == S_LOAD);
    // Completions are only meaningful inside a frame.
    assign blk_done    = bus.dctq_valid && (bus.addr == 6'd63) && (state_q != S_IDLE);
    assign in_flight   = blk_in_q - blk_out_q;
    // One extra bit so the last-block test cannot wrap at 2^FB_W - 1.
    assign blk_in_next = {1'b0, blk_in_q} + {{FB_W{1'b0}}, 1'b1};

    // Next-state and the combinational strobes derived from state.
    always_comb begin
        state_d      = state_q;
        start_c      = 1'b0;
        frame_done_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go_ok) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (row_acc && (row_q == 3'd7)) state_d = S_PEND;
            end
            S_PEND: begin
                // din_valid low means row 7 has already landed in the RAM.
                if (bus.ready && (in_flight < FB_W'(2)) && !din_valid_q) begin
                    start_c = 1'b1;
                    state_d = (blk_in_next < {1'b0, fb_q}) ? S_LOAD : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (blk_out_q == fb_q) begin
                    frame_done_c = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and the frame / block counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            fb_q      <= '0;
            blk_in_q  <= '0;
            blk_out_q <= '0;
            row_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && go_ok) begin
                fb_q      <= bus.frame_blocks;
                blk_in_q  <= '0;
                blk_out_q <= '0;
                row_q     <= 3'd0;
            end else begin
                if (start_c)  blk_in_q  <= blk_in_q + FB_W'(1);
                if (blk_done) blk_out_q <= blk_out_q + FB_W'(1);
                if (row_acc)  row_q     <= row_q + 3'd1;
            end
        end
    end

    // Registered RAM write port; data and address hold between writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            di_q        <= 64'd0;
            wa_q        <= 3'd0;
            be_q        <= 8'd0;
            din_valid_q <= 1'b0;
        end else if (row_acc) begin
            di_q        <= bus.host_data;
            wa_q        <= row_q;
            be_q        <= 8'hFF;
            din_valid_q <= 1'b1;
        end else begin
            be_q        <= 8'd0;
            din_valid_q <= 1'b0;
        end
    end

    assign bus.host_ready = (state_q == S_LOAD);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.start      = start_c;
    assign bus.frame_done = frame_done_c;
    assign bus.di         = di_q;
    assign bus.wa         = wa_q;
    assign bus.be         = be_q;
    assign bus.din_valid  = din_valid_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: doc/dctq_block_sched.md
DCTQ_BLOCK_SCHED -- requirements
Module: dctq_block_sched

Interface
REQ-001 Parameter FB_W, default 16, width of the frame block count and the block counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 frame_go  input  1  one-cycle pulse; starts a frame; ignored unless state IDLE.
REQ-005 frame_blocks  input  FB_W  number of 8x8 blocks in the frame; sampled only on an accepted frame_go.
REQ-006 host_valid  input  1  host row word valid.
REQ-007 host_data  input  64  one pixel row, eight unsigned 8-bit pixels, MSB byte = column 0.
REQ-008 host_ready  output  1  row accepted when host_valid and host_ready are both 1.
REQ-009 di  output  64  row data to DCTQ input RAM.
REQ-010 din_valid  output  1  write strobe to DCTQ input RAM.
REQ-011 wa  output  3  row address within block.
REQ-012 be  output  8  byte enables.
REQ-013 start  output  1  one-cycle pulse to DCTQ controller: block loaded.
REQ-014 ready  input  1  DCTQ controller ready for start.
REQ-015 dctq_valid  input  1  DCTQ coefficient valid.
REQ-016 addr  input  6  DCTQ coefficient address.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 frame_done  output  1  one-cycle pulse: last coefficient of the frame emitted.

Function
REQ-019 States: IDLE, LOAD, PEND, DRAIN. Encoding is free.
REQ-020 IDLE -> LOAD on frame_go with frame_blocks != 0. Latch frame_blocks. Clear blk_in, blk_out and row counter. frame_go with 0 is ignored.
REQ-021 host_ready shall be 1 only in LOAD. It is combinational from state.
REQ-022 On an accepted row, the cycle after shall show di = host_data, wa = row counter, be = 8'hFF, din_valid = 1. Otherwise din_valid = 0 and be = 0, and di/wa hold.
REQ-023 Row counter increments per accepted row and wraps 7 -> 0. Acceptance at row 7 moves LOAD -> PEND.
REQ-024 In-flight = blk_in - blk_out, maximum 2. blk_in counts start pulses; blk_out counts cycles with dctq_valid = 1 and addr = 6'd63.
REQ-025 In PEND, start shall pulse when ready = 1, in-flight < 2, and din_valid = 0 in the same cycle (last row already written). start shall never be high for two consecutive cycles.
REQ-026 In the start cycle, blk_in increments. Next state is LOAD if blk_in+1 < frame_blocks, else DRAIN.
REQ-027 A start and a block completion in the same cycle shall leave in-flight unchanged (both counters update).
REQ-028 DRAIN -> IDLE when blk_out = frame_blocks. frame_done shall pulse in the cycle after the final addr = 63 completion is counted, then busy = 0.
REQ-029 In IDLE, dctq_valid with addr = 63 shall not alter any counter.
REQ-030 frame_go outside IDLE shall have no effect.
REQ-031 Counters are FB_W bits. frame_blocks = 2^FB_W - 1 shall complete without overflow.
REQ-032 Latency: 8th accepted row to start is 2 cycles minimum (ready = 1, in-flight < 2).

Reset
REQ-033 With reset_n = 0 at a clk edge, the next state shall be IDLE. All counters = 0. host_ready, din_valid, start, busy, frame_done = 0. di = 0, wa = 0, be = 0.
REQ-034 Reset mid-frame shall abandon the frame with no start or frame_done pulse afterwards. The next frame_go shall begin cleanly.
REQ-035 Output values shall be valid in the first cycle after reset deassertion.

Verification
REQ-036 frame_go with frame_blocks = 1, 8 back-to-back rows, ready = 1 -> din_valid on 8 consecutive cycles with wa 0..7, be = FF. start 2 cycles after row 7. Feed 64 dctq_valid with addr 0..63 -> frame_done 1 cycle after addr 63, then busy = 0.
REQ-037 frame_blocks = 3, ready = 1, no dctq_valid returned -> 2 starts. Third block loads and stays in PEND with no start until one addr = 63 completion, then start pulses.
REQ-038 ready = 0 held 20 cycles in PEND -> host_ready = 0 and no start. Raise ready -> start on the next edge.
REQ-039 Same-cycle start and addr = 63 completion with in-flight = 1 -> in-flight stays 1. Frame finishes with exactly frame_blocks starts.
REQ-040 frame_go with frame_blocks = 0 -> stays IDLE, busy = 0. Reset asserted during row 4 of a block -> all outputs reset values, and a new 1-block frame completes normally.
